// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and limits for the wait-state data memory.
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} dmem_state_t;
  typedef enum logic {SZ_WORD, SZ_BYTE} acc_size_t;
  localparam int MAX_WAIT = 15;
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: inserts a write byte into a word and extracts the read byte at a lane.
module byte_lane_merge
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LW     = 2
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [7:0]        i_byte,
  input  logic [LW-1:0]     i_lane,
  input  logic              i_size,
  output logic [DATA_W-1:0] o_merged,
  output logic [7:0]        o_rbyte
);
  always_comb begin
    o_merged = i_old;
    if (i_size == SZ_BYTE) o_merged[i_lane*8 +: 8] = i_byte;
  end
  assign o_rbyte = i_old[i_lane*8 +: 8];
endmodule

// File: rtl/dmem_waitstate.sv
// dmem_waitstate: byte/word data memory with req/ready handshake and fixed wait states.
// One access outstanding; request fields are latched on accept.
module dmem_waitstate
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_err,
  output logic              o_busy
);
  localparam int LANES = DATA_W / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DATA_W % 8 != 0 || WAIT_STATES > MAX_WAIT || WAIT_STATES < 0) begin : g_bad_param
      $error("dmem_waitstate: DATA_W must be a multiple of 8 and WAIT_STATES within 0..15");
    end
  endgenerate

  dmem_state_t       r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_size;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic              w_we;
  logic              w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [LW-1:0]     w_lane;
  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic              w_commit;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_merged;
  logic [7:0]        w_rbyte;
  logic [DATA_W-1:0] w_wword;
  logic [DATA_W-1:0] w_rword;

  // With zero wait states the access commits on the accept edge, so it must use the live inputs.
  assign w_idle   = r_state == S_IDLE;
  assign w_we     = w_idle ? i_we    : r_we;
  assign w_size   = w_idle ? i_size  : r_size;
  assign w_addr   = w_idle ? i_addr  : r_addr;
  assign w_wdata  = w_idle ? i_wdata : r_wdata;
  assign w_lane   = w_addr[LW-1:0];
  assign w_idx    = w_addr >> LW;
  assign w_err    = (w_size == SZ_WORD && w_lane != '0) || (w_idx >= ADDR_W'(DEPTH));
  assign w_commit = (w_idle && i_req && WAIT_STATES == 0) || (r_state == S_WAIT && r_cnt == 4'd1);
  assign w_word   = r_mem[w_idx[IW-1:0]];

  byte_lane_merge #(.DATA_W(DATA_W), .LW(LW)) u_merge (
    .i_old   (w_word),
    .i_byte  (w_wdata[7:0]),
    .i_lane  (w_lane),
    .i_size  (w_size),
    .o_merged(w_merged),
    .o_rbyte (w_rbyte)
  );

  assign w_wword = (w_size == SZ_WORD) ? w_wdata : w_merged;
  assign w_rword = (w_size == SZ_BYTE) ? {{(DATA_W-8){1'b0}}, w_rbyte} : w_word;

  // RAM has no reset; a reset held across the commit edge suppresses the write.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_commit && w_we && !w_err) r_mem[w_idx[IW-1:0]] <= w_wword;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? '0 : w_rword;
      end
      if (w_idle && i_req) begin
        r_we    <= i_we;
        r_size  <= i_size;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= 4'(WAIT_STATES);
        r_state <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_state <= S_DONE;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_ready = r_state == S_DONE;
  assign o_err   = o_ready && r_err;
  assign o_busy  = i_rst_n && (r_state == S_WAIT || (w_idle && i_req));
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: random and directed accesses scored against a byte-array memory model.
module tb_dmem_waitstate;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, sz;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic        b_req, b_we, b_sz;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_ready, b_err, b_busy;

  always #5 clk = ~clk;

  dmem_waitstate #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(sz), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready), .o_err(err), .o_busy(busy)
  );

  dmem_waitstate #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(b_req), .i_we(b_we), .i_size(b_sz), .i_addr(b_addr),
    .i_wdata(b_wdata), .o_rdata(b_rdata), .o_ready(b_ready), .o_err(b_err), .o_busy(b_busy)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          due;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  logic [7:0] mem_ref [256];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.due    = 0;
    e.rd     = '0;
    e.err    = (!s && a % 4 != 0) || (a / 4 >= 64);
    e.chk_rd = !w || e.err;
    if (!e.err) begin
      if (w && s) mem_ref[a[7:0]] = d[7:0];
      else if (w) for (int i = 0; i < 4; i++) mem_ref[{a[7:2], 2'(i)}] = d[8*i +: 8];
      else if (s) e.rd = {24'h0, mem_ref[a[7:0]]};
      else e.rd = {mem_ref[{a[7:2], 2'd3}], mem_ref[{a[7:2], 2'd2}], mem_ref[{a[7:2], 2'd1}], mem_ref[{a[7:2], 2'd0}]};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        m_e = q.pop_front();
        chk("err", {31'd0, err}, {31'd0, m_e.err});
        if (m_e.chk_rd) chk("rdata", rdata, m_e.rd);
        chk("latency", cyc, m_e.due);
      end
    end
  end

  // Called at a falling edge with the memory idle; returns at a falling edge with it idle again.
  task automatic do_acc(input logic w, input logic s, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    req = 1'b1; we = w; sz = s; addr = a; wdata = d;
    e = model(w, s, a, d);
    e.due = cyc + 1 + WS;
    q.push_back(e);
    @(posedge clk);
    #1;
    we = 1'($urandom); sz = 1'($urandom); addr = $urandom; wdata = $urandom;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) break;
      chk("busy_wait", {31'd0, busy}, 32'd1);
    end
    if (n == 20) chk("ready_timeout", 32'd0, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    req = 1'($urandom);
    addr = $urandom_range(0, 255);
    @(negedge clk);
    req = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, exp_b;
    logic [31:0] wv [4];
    logic        w, s;
    int          r, j;
    rst_n = 1'b0;
    req = 1'b1; we = 1'b1; sz = 1'b0; addr = 32'h64; wdata = 32'hFFFF_FFFF;
    b_req = 1'b0; b_we = 1'b0; b_sz = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 64; k++) do_acc(1'b1, 1'b0, 32'(k * 4), $urandom);
    do_acc(1'b1, 1'b0, 32'h64, 32'h0000_0007);
    do_acc(1'b0, 1'b0, 32'h64, 32'h0);
    do_acc(1'b1, 1'b0, 32'h60, 32'h1122_3344);
    do_acc(1'b1, 1'b1, 32'h61, 32'h0000_00AB);
    do_acc(1'b0, 1'b0, 32'h60, 32'h0);
    do_acc(1'b0, 1'b1, 32'h63, 32'h0);
    do_acc(1'b1, 1'b0, 32'h66, 32'h5555_5555);
    do_acc(1'b0, 1'b0, 32'h64, 32'h0);
    do_acc(1'b0, 1'b0, 32'h100, 32'h0);
    do_acc(1'b0, 1'b1, 32'h101, 32'h0);
    rst_n = 1'b0;
    req = 1'b1; we = 1'b1; sz = 1'b0; addr = 32'h68; wdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("rst2_ready", {31'd0, ready}, 32'd0);
      chk("rst2_busy", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    req = 1'b0;
    @(negedge clk);
    do_acc(1'b0, 1'b0, 32'h68, 32'h0);
    req = 1'b1; we = 1'b1; sz = 1'b0; addr = 32'h68; wdata = 32'h0000_DEAD;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_ready", {31'd0, ready}, 32'd0);
      chk("mid_busy_rst", {31'd0, busy}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (WS + 3) @(negedge clk);
    do_acc(1'b0, 1'b0, 32'h68, 32'h0);
    repeat (300) begin
      r = $urandom_range(0, 9);
      w = 1'($urandom);
      s = 1'($urandom);
      d = $urandom;
      a = (r < 7) ? 32'($urandom_range(0, 255)) : (r < 9) ? 32'($urandom_range(256, 511)) : $urandom;
      if (!s && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_acc(w, s, a, d);
    end
    for (int k = 0; k < 4; k++) wv[k] = $urandom;
    b_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      j = k % 4;
      b_we = k < 4;
      b_sz = k >= 8;
      b_addr = (k >= 8) ? 32'(j * 5) : 32'(j * 4);
      b_wdata = wv[j];
      exp_b = (k >= 8) ? (wv[j] >> (8 * j)) & 32'hFF : wv[j];
      #1;
      chk("b_busy_idle", {31'd0, b_busy}, 32'd1);
      chk("b_ready_idle", {31'd0, b_ready}, 32'd0);
      @(negedge clk);
      chk("b_ready", {31'd0, b_ready}, 32'd1);
      chk("b_busy_done", {31'd0, b_busy}, 32'd0);
      chk("b_err", {31'd0, b_err}, 32'd0);
      if (k >= 4) chk("b_rdata", b_rdata, exp_b);
      @(negedge clk);
    end
    b_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
